// File: rtl/pipe_skid_stage.sv
// Registered valid/ready pipeline stage with a 2-entry skid buffer.
// All outputs come straight from flops; flush squashes buffered words.
module pipe_skid_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic               main_valid_q, main_valid_n;
  logic [WIDTH-1:0]   main_data_q, main_data_n;
  logic               skid_valid_q, skid_valid_n;
  logic [WIDTH-1:0]   skid_data_q, skid_data_n;
  logic               in_ready_q, in_ready_n;
  logic [CNT_W-1:0]   xfer_q, xfer_n;

  logic accept;
  logic out_ev;

  assign accept = in_valid & in_ready_q;
  assign out_ev = main_valid_q & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_EMPTY;
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
      xfer_q       <= '0;
    end else begin
      state_q      <= state_n;
      main_valid_q <= main_valid_n;
      main_data_q  <= main_data_n;
      skid_valid_q <= skid_valid_n;
      skid_data_q  <= skid_data_n;
      in_ready_q   <= in_ready_n;
      xfer_q       <= xfer_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    main_valid_n = main_valid_q;
    main_data_n  = main_data_q;
    skid_valid_n = skid_valid_q;
    skid_data_n  = skid_data_q;
    in_ready_n   = in_ready_q;
    // The consumer sampled the word, so the transfer counts even under flush.
    xfer_n       = out_ev ? xfer_q + 1'b1 : xfer_q;

    if (flush) begin
      state_n      = S_EMPTY;
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
      in_ready_n   = 1'b1;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_data_n  = in_data;
            main_valid_n = 1'b1;
            state_n      = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && out_ev) begin
            main_data_n = in_data;
          end else if (accept) begin
            skid_data_n  = in_data;
            skid_valid_n = 1'b1;
            in_ready_n   = 1'b0;
            state_n      = S_FULL;
          end else if (out_ev) begin
            main_valid_n = 1'b0;
            state_n      = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_ev) begin
            main_data_n  = skid_data_q;
            skid_valid_n = 1'b0;
            in_ready_n   = 1'b1;
            state_n      = S_ONE;
          end
        end
        default: begin
          state_n      = S_EMPTY;
          main_valid_n = 1'b0;
          skid_valid_n = 1'b0;
          in_ready_n   = 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid_q;
  assign out_data   = main_data_q;
  assign occupancy  = state_q;
  assign xfer_count = xfer_q;

endmodule
